dg_gate_tt_sequencer: RTL and testbench

Truth-table characterisation sequencer for a single 4-input, 1-output cell model, including cells with a floating (tri-state) output. It steps the device under test through all 16 input vectors and waits a programmable settle time per vector. It records each response as low, high or floating and compares the result against an expected table. It sits in the cell-verification bench, between a bench controller (start/done handshake) and one cell instance.

---
 rtl/dg_gate_tt_sequencer.sv | 140 ++++++++++++++
 tb/tb_dg_gate_tt_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dg_gate_tt_sequencer.sv
// Truth-table characterisation sequencer for a 4-input, 1-output cell model.
// Steps {a,b,c,d} through all 16 vectors and holds each one for SETTLE+1 cycles.
// It captures each response as low (00), high (01) or floating (10).
// Each capture is compared against EXP_TT, where 11 marks a don't-care entry.
// Optional feature macro: DG_TT_STOP_ON_MISMATCH_EN. When it is defined, the run
// ends at the first mismatching capture.
module dg_gate_tt_sequencer #(
  parameter int unsigned SETTLE = 2,
  parameter logic [31:0] EXP_TT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        y,
  input  logic        y_z,
  output logic        busy,
  output logic        done,
  output logic [31:0] tt,
  output logic [15:0] mismatch,
  output logic [4:0]  mism_cnt,
  output logic        pass,
  output logic        aborted
);

  // A settle value of 0 is treated as 1, so every vector is held at least 2 cycles.
  localparam int unsigned SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int unsigned HOLD       = SETTLE_EFF + 1;
  localparam int unsigned CW         = $clog2(HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

  // NEXT and DONE are folded into the capture edge, so only two states are needed.
  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;

  logic          accept_c;
  logic          capture_c;
  logic          miss_c;
  logic          stop_c;
  logic          finish_c;
  logic [1:0]    cap_code_c;
  logic [1:0]    exp_code_c;
  logic [4:0]    cnt_nxt_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = DRIVE;
      DRIVE:   if (finish_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes: run acceptance, capture, compare result and end-of-run
  always_comb begin
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    cap_code_c = y_z ? 2'b10 : {1'b0, y};
    exp_code_c = EXP_TT[{idx, 1'b0} +: 2];
    case (state)
      IDLE:    accept_c  = start;
      DRIVE:   capture_c = (cnt == CNT_LAST);
      default: ;
    endcase
    miss_c = capture_c && (exp_code_c != 2'b11) && (cap_code_c != exp_code_c);
`ifdef DG_TT_STOP_ON_MISMATCH_EN
    stop_c = miss_c;
`else
    stop_c = 1'b0;
`endif
    finish_c  = capture_c && ((idx == 4'd15) || stop_c);
    cnt_nxt_c = mism_cnt + 5'(miss_c);
  end

  // Datapath: vector drive, settle counter, capture, compare and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      idx          <= 4'd0;
      cnt          <= '0;
      {a, b, c, d} <= 4'b0000;
      tt           <= 32'h0;
      mismatch     <= 16'h0;
      mism_cnt     <= 5'd0;
      pass         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        busy         <= 1'b1;
        idx          <= 4'd0;
        cnt          <= '0;
        {a, b, c, d} <= 4'b0000;
        tt           <= 32'h0;
        mismatch     <= 16'h0;
        mism_cnt     <= 5'd0;
        pass         <= 1'b0;
        aborted      <= 1'b0;
      end else if (state == DRIVE) begin
        if (capture_c) begin
          tt[{idx, 1'b0} +: 2] <= cap_code_c;
          mismatch[idx]        <= miss_c;
          mism_cnt             <= cnt_nxt_c;
          cnt                  <= '0;
          if (finish_c) begin
            busy         <= 1'b0;
            done         <= 1'b1;
            {a, b, c, d} <= 4'b0000;
            aborted      <= stop_c;
            pass         <= (cnt_nxt_c == 5'd0) && !stop_c;
          end else begin
            idx          <= idx + 4'd1;
            {a, b, c, d} <= idx + 4'd1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dg_gate_tt_sequencer.sv
// Bench for dg_gate_tt_sequencer. Four instances share one clock and one reset.
//   0: NAND(a,b) cell, SETTLE=2, EXP_TT = exact NAND table
//   1: NAND(a,b) cell, SETTLE=2, entry 0 expected low (one mismatch)
//   2: NAND(a,b) cell floating on 0101/1010 with y=1, entries 5/10 don't-care
//   3: NAND(a,b) cell, SETTLE=0 (behaves as SETTLE=1)
module tb_dg_gate_tt_sequencer;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [NI];
  logic        va [NI];
  logic        vb [NI];
  logic        vc [NI];
  logic        vd [NI];
  logic        y [NI];
  logic        yz [NI];
  logic        busy [NI];
  logic        done [NI];
  logic [31:0] tt [NI];
  logic [15:0] mis [NI];
  logic [4:0]  mcnt [NI];
  logic        pass [NI];
  logic        abrt [NI];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Device instances, each with its own cell model
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned ST = (g == 3) ? 0 : 2;
    localparam logic [31:0] EX = (g == 1) ? 32'h0055_5554 :
                                 (g == 2) ? 32'h0075_5D55 : 32'h0055_5555;
    logic [3:0] vec;
    assign vec   = {va[g], vb[g], vc[g], vd[g]};
    assign yz[g] = (g == 2) && ((vec == 4'h5) || (vec == 4'hA));
    assign y[g]  = yz[g] | ~(vec[3] & vec[2]);

    dg_gate_tt_sequencer #(.SETTLE(ST), .EXP_TT(EX)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .a        (va[g]),
      .b        (vb[g]),
      .c        (vc[g]),
      .d        (vd[g]),
      .y        (y[g]),
      .y_z      (yz[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .tt       (tt[g]),
      .mismatch (mis[g]),
      .mism_cnt (mcnt[g]),
      .pass     (pass[g]),
      .aborted  (abrt[g])
    );
  end

  typedef struct {
    int          k;
    logic [31:0] tt;
    logic [15:0] mis;
    logic [4:0]  cnt;
    logic        pass;
    logic        ab;
    int          nvec;
  } run_t;

  run_t       runs [4];
  logic [1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] vec_of(input int k);
    return {va[k], vb[k], vc[k], vd[k]};
  endfunction

  function automatic int hold_of(input int k);
    return (k == 3) ? 2 : 3;
  endfunction

  // Response of the cell model: floating wins over y, otherwise NAND(a,b)
  function automatic logic [1:0] model_code(input int k, input int i);
    if (k == 2 && (i == 5 || i == 10)) return 2'b10;
    return (i >= 12) ? 2'b00 : 2'b01;
  endfunction

  function automatic run_t mk_run(input int k, input logic [31:0] t, input logic [15:0] m,
                                  input logic [4:0] c, input logic p, input logic ab, input int nv);
    run_t r;
    r.k = k; r.tt = t; r.mis = m; r.cnt = c; r.pass = p; r.ab = ab; r.nvec = nv;
    return r;
  endfunction

  task automatic chk_reset(input int k, input string tag);
    chk({tag, "_busy"}, 32'(busy[k]), 0);
    chk({tag, "_done"}, 32'(done[k]), 0);
    chk({tag, "_tt"}, tt[k], 0);
    chk({tag, "_mis"}, 32'(mis[k]), 0);
    chk({tag, "_cnt"}, 32'(mcnt[k]), 0);
    chk({tag, "_pass"}, 32'(pass[k]), 0);
    chk({tag, "_abrt"}, 32'(abrt[k]), 0);
    chk({tag, "_vec"}, 32'(vec_of(k)), 0);
  endtask

  // One full run: per-vector hold/capture through the scoreboard, then final results
  task automatic do_run(input run_t r);
    int k;
    int hold;
    logic [1:0] code;
    k    = r.k;
    hold = hold_of(k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    chk("busy_at_t0", 32'(busy[k]), 1);
    chk("tt_cleared", tt[k], 0);
    chk("cnt_cleared", 32'(mcnt[k]), 0);
    chk("pass_cleared", 32'(pass[k]), 0);
    for (int i = 0; i < r.nvec; i++) begin
      sb.push_back(model_code(k, i));
      for (int j = 0; j < hold; j++) begin
        chk($sformatf("vec_hold_k%0d_i%0d", k, i), 32'(vec_of(k)), 32'(i));
        chk("busy_run", 32'(busy[k]), 1);
        chk("done_low_run", 32'(done[k]), 0);
        tick();
      end
      code = sb.pop_front();
      chk($sformatf("tt_entry_k%0d_i%0d", k, i), 32'(tt[k][2*i +: 2]), 32'(code));
    end
    chk($sformatf("done_k%0d", k), 32'(done[k]), 1);
    chk("busy_end", 32'(busy[k]), 0);
    chk("vec_end", 32'(vec_of(k)), 0);
    chk($sformatf("tt_k%0d", k), tt[k], r.tt);
    chk($sformatf("mis_k%0d", k), 32'(mis[k]), 32'(r.mis));
    chk($sformatf("mism_cnt_k%0d", k), 32'(mcnt[k]), 32'(r.cnt));
    chk($sformatf("pass_k%0d", k), 32'(pass[k]), 32'(r.pass));
    chk($sformatf("aborted_k%0d", k), 32'(abrt[k]), 32'(r.ab));
    tick();
    chk("done_one_cycle", 32'(done[k]), 0);
    chk("pass_holds", 32'(pass[k]), 32'(r.pass));
    chk("tt_holds", tt[k], r.tt);
  endtask

  initial begin
    int seen;
    logic exp_done;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) start[k] = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < NI; k++) chk_reset(k, "rst_held");
    rst = 1'b0;
    tick();
    for (int k = 0; k < NI; k++) chk_reset(k, "idle");

    runs[0] = mk_run(0, 32'h0055_5555, 16'h0000, 5'd0, 1'b1, 1'b0, 16);
`ifdef DG_TT_STOP_ON_MISMATCH_EN
    runs[1] = mk_run(1, 32'h0000_0001, 16'h0001, 5'd1, 1'b0, 1'b1, 1);
`else
    runs[1] = mk_run(1, 32'h0055_5555, 16'h0001, 5'd1, 1'b0, 1'b0, 16);
`endif
    runs[2] = mk_run(2, 32'h0065_5955, 16'h0000, 5'd0, 1'b1, 1'b0, 16);
    runs[3] = mk_run(3, 32'h0055_5555, 16'h0000, 5'd0, 1'b1, 1'b0, 16);

    for (int r = 0; r < 4; r++) do_run(runs[r]);

    // Reset and start in the same cycle: reset wins and held results are cleared
    rst = 1'b1;
    start[0] = 1'b1;
    tick();
    chk_reset(0, "rst_and_start");
    rst = 1'b0;
    start[0] = 1'b0;
    tick();
    chk("rst_and_start_idle", 32'(busy[0]), 0);

    // Reset at edge t0+20: immediate return to IDLE and no done pulse
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (19) tick();
    chk("busy_before_midrst", 32'(busy[0]), 1);
    rst = 1'b1;
    tick();
    chk_reset(0, "mid_rst");
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      tick();
      if (done[0]) seen++;
    end
    chk("no_done_after_rst", 32'(seen), 0);
    chk("busy_after_rst", 32'(busy[0]), 0);
    do_run(runs[0]);

    // Start held high: runs accepted only in IDLE; done every 49 cycles; busy low only on done
    start[0] = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      exp_done = ((n % 49) == 0);
      chk($sformatf("held_done_n%0d", n), 32'(done[0]), 32'(exp_done));
      chk($sformatf("held_busy_n%0d", n), 32'(busy[0]), 32'(!exp_done));
    end
    start[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_reset(0, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
